// File: rtl/spi_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_buffer
// Purpose  : Ping-pong two-bank frame store between SPI byte reader and consumer.
// Revision : 1.0
// ============================================================================
module spi_frame_buffer #(
    parameter int FRAME_BYTES = 35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       frame_ready,
    input  logic       frame_ack,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] frame_count,
    output logic       overrun,
    output logic       short_frame,
    input  logic       clear_flags
);

    localparam logic [5:0] c_last_ptr  = 6'(FRAME_BYTES - 1);
    localparam logic [5:0] c_num_bytes = 6'(FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_wr_ptr;
    logic        r_wr_bank;
    logic        r_rd_bank;
    logic [1:0]  r_full;
    logic [1:0]  w_full_next;
    logic [7:0]  r_frame_count;
    logic        r_overrun;
    logic        r_short_frame;
    logic [7:0]  r_rd_data;
    logic [7:0]  w_rd_byte;
    logic        w_wr_en;
    logic        w_ptr_clear;
    logic        w_complete;
    logic        w_set_overrun;
    logic        w_set_short;
    logic        w_ack;

    logic [7:0]  r_mem [2][FRAME_BYTES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A new frame only starts in a bank the consumer has released.
    always_comb begin
        w_state_next  = r_state;
        w_wr_en       = 1'b0;
        w_ptr_clear   = 1'b0;
        w_complete    = 1'b0;
        w_set_overrun = 1'b0;
        w_set_short   = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (frame_start) begin
                    w_set_short = 1'b1;
                    w_ptr_clear = 1'b1;
                end else if (byte_valid) begin
                    w_wr_en = 1'b1;
                    if (r_wr_ptr == c_last_ptr) begin
                        w_complete   = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                if (frame_start) begin
                    if (!r_full[r_wr_bank]) begin
                        w_state_next = ST_FILL;
                        w_ptr_clear  = 1'b1;
                    end else begin
                        w_state_next  = ST_DROP;
                        w_set_overrun = 1'b1;
                    end
                end
            end
        endcase
    end

    assign w_ack = frame_ack & r_full[r_rd_bank];

    // Completion and release always address different banks.
    always_comb begin
        w_full_next = r_full;
        if (w_complete) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_ack) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    assign w_rd_byte = (rd_addr < c_num_bytes) ? r_mem[r_rd_bank][rd_addr] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= 6'd0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_full        <= 2'b00;
            r_frame_count <= 8'd0;
            r_overrun     <= 1'b0;
            r_short_frame <= 1'b0;
            r_rd_data     <= 8'h00;
        end else begin
            if (w_ptr_clear || w_complete) begin
                r_wr_ptr <= 6'd0;
            end else if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 6'd1;
            end
            if (w_complete) begin
                r_wr_bank     <= ~r_wr_bank;
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_ack) begin
                r_rd_bank <= ~r_rd_bank;
            end
            r_full <= w_full_next;
            if (w_set_overrun) begin
                r_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_overrun <= 1'b0;
            end
            if (w_set_short) begin
                r_short_frame <= 1'b1;
            end else if (clear_flags) begin
                r_short_frame <= 1'b0;
            end
            r_rd_data <= w_rd_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][r_wr_ptr] <= byte_data;
        end
    end

    assign frame_ready = r_full[r_rd_bank];
    assign rd_data     = r_rd_data;
    assign frame_count = r_frame_count;
    assign overrun     = r_overrun;
    assign short_frame = r_short_frame;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_buffer
// Purpose  : Scoreboard bench for spi_frame_buffer with a behavioural frame model.
// Revision : 1.0
// ============================================================================
module tb_spi_frame_buffer;

    localparam int FRAME_BYTES = 35;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       frame_ready;
    logic       frame_ack = 1'b0;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data;
    logic [7:0] frame_count;
    logic       overrun;
    logic       short_frame;
    logic       clear_flags = 1'b0;

    spi_frame_buffer #(.FRAME_BYTES(FRAME_BYTES)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_count (frame_count),
        .overrun     (overrun),
        .short_frame (short_frame),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;

    // behavioural model: 0 idle, 1 fill, 2 drop
    int         m_state = 0;
    int         m_cnt   = 0;
    int         m_base  = 0;
    logic [7:0] m_count = 8'd0;
    bit         m_over  = 1'b0;
    bit         m_short = 1'b0;
    int         exp_frames[$];
    logic [7:0] sb[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_count = 8'd0;
        m_over  = 1'b0;
        m_short = 1'b0;
        exp_frames.delete();
    endtask

    task automatic drive_cycle(input bit start, input bit valid, input logic [7:0] data,
                               input bit ack, input bit clr);
        int n_before;
        frame_start = start;
        byte_valid  = valid;
        byte_data   = data;
        frame_ack   = ack;
        clear_flags = clr;
        n_before = exp_frames.size();
        if (clr) begin
            m_over  = 1'b0;
            m_short = 1'b0;
        end
        if (start) begin
            if (m_state == 1) begin
                m_short = 1'b1;
                m_cnt   = 0;
            end else if (n_before < 2) begin
                m_state = 1;
                m_cnt   = 0;
            end else begin
                m_state = 2;
                m_over  = 1'b1;
            end
        end
        if (ack && n_before > 0) begin
            void'(exp_frames.pop_front());
        end
        if (!start && valid && m_state == 1) begin
            m_cnt++;
            if (m_cnt == FRAME_BYTES) begin
                exp_frames.push_back(m_base);
                m_count = m_count + 8'd1;
                m_state = 0;
            end
        end
        tick();
        frame_start = 1'b0;
        byte_valid  = 1'b0;
        frame_ack   = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic send_frame(input int base, input int nbytes, input bit ack_last);
        m_base = base;
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            drive_cycle(1'b0, 1'b1, 8'((base + i) & 8'hFF), ack_last && (i == nbytes - 1), 1'b0);
        end
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_ready"}, 32'(frame_ready), 32'(exp_frames.size() > 0));
        check_val({tag, "_count"}, 32'(frame_count), 32'(m_count));
        check_val({tag, "_overrun"}, 32'(overrun), 32'(m_over));
        check_val({tag, "_short"}, 32'(short_frame), 32'(m_short));
    endtask

    task automatic read_check(input int addr, input string tag);
        logic [7:0] exp;
        exp = 8'h00;
        if (addr < FRAME_BYTES && exp_frames.size() > 0) begin
            exp = 8'((exp_frames[0] + addr) & 8'hFF);
        end
        sb.push_back(exp);
        rd_addr = 6'(addr);
        tick();
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check_val(tag, 32'(rd_data), 32'(sb.pop_front()));
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_status(tag);
        check_val({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #3;
        do_reset("rst");

        // single frame and address boundaries
        send_frame(8'h00, FRAME_BYTES, 1'b0);
        check_status("f1");
        read_check(5, "f1_rd5");
        read_check(40, "f1_rd40");
        read_check(34, "f1_rd34");
        read_check(35, "f1_rd35");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_status("f1_ack");

        // two frames, delivered in order
        send_frame(8'h10, FRAME_BYTES, 1'b0);
        send_frame(8'h80, FRAME_BYTES, 1'b0);
        check_status("ab");
        read_check(0, "ab_rdA0");
        read_check(34, "ab_rdA34");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        read_check(0, "ab_rdB0");
        read_check(17, "ab_rdB17");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_status("ab_empty");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_status("ab_ack_idle");

        // overrun with both banks full
        send_frame(8'h10, FRAME_BYTES, 1'b0);
        send_frame(8'h80, FRAME_BYTES, 1'b0);
        send_frame(8'hC0, FRAME_BYTES, 1'b0);
        check_status("ovr");
        read_check(3, "ovr_rdA3");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_status("ovr_clr");
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_status("ovr_setwins");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        read_check(1, "ovr_rdB1");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_status("ovr_drained");

        // aborted frame followed by a full one
        send_frame(8'h60, 10, 1'b0);
        send_frame(8'hA0, FRAME_BYTES, 1'b0);
        check_status("short");
        read_check(0, "short_rd0");
        read_check(12, "short_rd12");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check_status("short_clr");

        // stray bytes in IDLE are ignored
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        end
        check_status("idle_bytes");

        // completion coinciding with release of the older frame
        send_frame(8'h30, FRAME_BYTES, 1'b0);
        send_frame(8'h50, FRAME_BYTES, 1'b1);
        check_status("coinc");
        read_check(0, "coinc_rd0");
        read_check(10, "coinc_rd10");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check_status("coinc_empty");

        // reset in the middle of a frame
        send_frame(8'h70, 20, 1'b0);
        do_reset("midrst");
        check_status("midrst_after");
        send_frame(8'h90, FRAME_BYTES, 1'b0);
        check_status("post_rst");
        read_check(3, "post_rst_rd3");
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // frame_count wraps from 255 to 0
        for (int f = 0; f < 255; f++) begin
            send_frame(f, FRAME_BYTES, 1'b0);
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        check_status("wrap");
        check_val("wrap_zero", 32'(frame_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_frame_buffer.md
SPI_FRAME_BUFFER -- requirements
Module: spi_frame_buffer

Interface
REQ-001 Parameter: FRAME_BYTES, default 35, number of bytes per READSSR frame (range 2..63).
REQ-002 clk  input  1  system clock (HFOSC domain); all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 frame_start  input  1  one-cycle pulse marking the start of a new frame from the SPI reader.
REQ-005 byte_valid  input  1  one-cycle strobe; byte_data holds a received byte.
REQ-006 byte_data  input  8  received SPI byte.
REQ-007 frame_ready  output  1  high while the oldest complete frame is available to the consumer.
REQ-008 frame_ack  input  1  one-cycle pulse from the consumer releasing the current frame.
REQ-009 rd_addr  input  6  byte index into the current read frame.
REQ-010 rd_data  output  8  registered read data.
REQ-011 frame_count  output  8  count of completed frames.
REQ-012 overrun  output  1  sticky: a frame was dropped because no bank was free.
REQ-013 short_frame  output  1  sticky: a frame was aborted before FRAME_BYTES bytes.
REQ-014 clear_flags  input  1  one-cycle pulse clearing overrun and short_frame.

Function
REQ-015 Storage SHALL be two banks of FRAME_BYTES x 8 (ping-pong), each with a full flag; wr_bank selects fill target, rd_bank selects the oldest frame.
REQ-016 Write FSM states SHALL be IDLE, FILL, DROP.
REQ-017 IDLE: on frame_start, if full[wr_bank]==0 -> FILL with wr_ptr=0; else -> DROP and set overrun.
REQ-018 FILL: each byte_valid SHALL write byte_data to bank[wr_bank][wr_ptr] and increment wr_ptr.
REQ-019 FILL: the byte_valid with wr_ptr==FRAME_BYTES-1 SHALL, on that edge, set full[wr_bank], toggle wr_bank, increment frame_count (255 wraps to 0), -> IDLE.
REQ-020 FILL: frame_start SHALL abort the partial frame, set short_frame, reset wr_ptr to 0, remain in FILL on the same bank; a coincident byte_valid is discarded.
REQ-021 DROP: byte_valid ignored; frame_start re-evaluates as in REQ-017.
REQ-022 IDLE: byte_valid without a preceding frame_start SHALL be ignored.
REQ-023 frame_ready SHALL equal full[rd_bank] (combinational from registers).
REQ-024 frame_ack while frame_ready SHALL clear full[rd_bank] and toggle rd_bank on that edge; frame_ack while not ready is ignored.
REQ-025 Frame completion and frame_ack in the same cycle SHALL both take effect (they always address different banks).
REQ-026 rd_data SHALL be bank[rd_bank][rd_addr] registered, one-cycle latency; rd_addr >= FRAME_BYTES returns 8'h00.
REQ-027 Writes SHALL never target a bank whose full flag is set.
REQ-028 clear_flags and a same-cycle setting event: set SHALL win.
REQ-029 Frames SHALL be delivered in completion order; at most two frames are buffered.

Reset
REQ-030 rst SHALL force: FSM IDLE, wr_ptr=0, wr_bank=0, rd_bank=0, full=2'b00, frame_count=0, overrun=0, short_frame=0, rd_data=0; frame_ready=0.
REQ-031 Bank contents SHALL NOT be reset; they are undefined until written.
REQ-032 rst asserted mid-FILL SHALL discard the partial frame with no flag set after release.

Verification
REQ-033 Reset, frame_start, 35 bytes 0x00..0x22 -> frame_ready=1 the cycle after byte 35, frame_count=1; rd_addr=5 -> rd_data=0x05 one cycle later; rd_addr=40 -> 0x00.
REQ-034 Two full frames (A: 0x10.., B: 0x80..) without ack -> frame_ready=1, reads return A; frame_ack -> next cycle reads return B; second ack -> frame_ready=0.
REQ-035 Two frames buffered, third frame_start + 35 bytes -> overrun=1, frame_count stays 2, banks unchanged; clear_flags -> overrun=0.
REQ-036 frame_start, 10 bytes, frame_start, 35 bytes 0xA0.. -> short_frame=1, frame_count=1, rd_addr=0 returns 0xA0.
REQ-037 One frame buffered; completion of the second frame and frame_ack in the same cycle -> frame_ready stays 1, reads return second frame, frame_count=2.
REQ-038 rst pulsed after 20 bytes of a frame -> all outputs at reset values; a following full frame completes normally with frame_count=1.
